alu_writeback_stage: RTL and testbench

- Consumer end of the ALU result interface.
- Accepts one ALU result per cycle under a valid/ready handshake, classifies it by ALU op code, and updates the architectural NZCV flag register.
- Queues register-writing results in a 2-entry buffer toward the register-file write port.
- Feeds the stored C flag back to the ALU `c_in`; sits between the combinational ALU and the register file.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/wb_fifo2.sv | 74 +++++++
 rtl/alu_writeback_stage.sv | 104 ++++++++++
 tb/tb_alu_writeback_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op-code encoding, op classification helpers and NZCV bit positions.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_LSL = 4'h2;
  localparam logic [3:0] OP_LSR = 4'h3;
  localparam logic [3:0] OP_ASR = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_ROR = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_NEG = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MUL = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  // Compare ops only produce flags; they never write the register file.
  function automatic logic is_compare(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Arithmetic ops are the only ones whose C and V outputs are meaningful.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADC) || (op == OP_SBC) || (op == OP_NEG) ||
           (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Generic 2-entry valid/ready FIFO; the head register drives the output and
// keeps its last value when the FIFO drains. flush_i empties it and drops a same-cycle push.
module wb_fifo2 #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         ready_o,
  output logic         valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] data_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  // Ready depends only on the registered count, so there is no in->out combinational path.
  assign ready_o = (count_q != 2'd2);
  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign push    = push_i && ready_o;
  assign pop     = valid_o && pop_ready_i;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = push_data_i;
          else                 tail_d = push_data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = tail_q;
            tail_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the storage is reset too, because out_rd/out_data must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU result consumer: updates NZCV, queues register writes in a 2-entry FIFO.
// Optional sticky overflow flag (q_flag/q_clr) when ALU_WB_STICKY_Q_EN is defined.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_s,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_c,
  input  logic              in_z,
  input  logic              in_n,
  input  logic              in_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [3:0]        nzcv,
  output logic              c_to_alu
`ifdef ALU_WB_STICKY_Q_EN
  ,
  input  logic              q_clr,
  output logic              q_flag
`endif
);

  localparam int FIFO_W = RD_W + DATA_W;

  logic              accept;
  logic              push;
  logic [FIFO_W-1:0] head;
  logic [3:0]        nzcv_q, nzcv_d;

  assign accept = in_valid && in_ready;
  assign push   = accept && !is_compare(in_op);

  wb_fifo2 #(.W(FIFO_W)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ({in_rd, in_result}),
    .ready_o     (in_ready),
    .valid_o     (out_valid),
    .pop_ready_i (out_ready),
    .data_o      (head)
  );

  assign out_rd   = head[FIFO_W-1:DATA_W];
  assign out_data = head[DATA_W-1:0];

  // Compares always set flags; others only on in_s. Logic ops leave C and V alone.
  always_comb begin
    nzcv_d = nzcv_q;
    if (accept && (is_compare(in_op) || in_s)) begin
      nzcv_d[N_IDX] = in_n;
      nzcv_d[Z_IDX] = in_z;
      if (is_arith(in_op)) begin
        nzcv_d[C_IDX] = in_c;
        nzcv_d[V_IDX] = in_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nzcv_q <= 4'b0000;
    else        nzcv_q <= nzcv_d;
  end

  assign nzcv     = nzcv_q;
  assign c_to_alu = nzcv_q[C_IDX];

`ifdef ALU_WB_STICKY_Q_EN
  logic q_q, q_d;

  // Set beats a simultaneous clear so an overflow is never lost.
  always_comb begin
    q_d = q_q;
    if (accept && is_arith(in_op) && in_v) q_d = 1'b1;
    else if (q_clr)                         q_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q_flag = q_q;
`endif

`ifndef SYNTHESIS
  a_op_known: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> !$isunknown(in_op));
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: a driver feeds directed and random
// results through a behavioural model; a monitor checks every register-file write.
module tb_alu_writeback_stage;

  localparam logic [3:0] LSL = 4'h2, ADC = 4'h5, SBC = 4'h6, TST = 4'h8, NEG = 4'h9;
  localparam logic [3:0] CMP = 4'hA, CMN = 4'hB, ORR = 4'hC;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_s, in_c, in_z, in_n, in_v;
  logic [3:0]  in_op, in_rd, out_rd, nzcv;
  logic [31:0] in_result, out_data;
  logic        out_valid, out_ready, flush, c_to_alu;
  logic        q_clr, q_flag;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state.
  logic [35:0] exp_q[$];
  int          mcount;
  logic        fn, fz, fc, fv, mq;

  alu_writeback_stage #(.DATA_W(32), .RD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_s      (in_s),
    .in_result (in_result),
    .in_c      (in_c),
    .in_z      (in_z),
    .in_n      (in_n),
    .in_v      (in_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .flush     (flush),
    .nzcv      (nzcv),
    .c_to_alu  (c_to_alu)
`ifdef ALU_WB_STICKY_Q_EN
    ,
    .q_clr     (q_clr),
    .q_flag    (q_flag)
`endif
  );

`ifndef ALU_WB_STICKY_Q_EN
  assign q_flag = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit model_is_cmp(input logic [3:0] op);
    return op inside {TST, CMP, CMN};
  endfunction

  function automatic bit model_is_arith(input logic [3:0] op);
    return op inside {ADC, SBC, NEG, CMP, CMN};
  endfunction

  // One cycle: check state left by the previous edge, drive new inputs, advance the model.
  task automatic step(input bit v, input logic [3:0] op, input logic [3:0] rd, input bit s,
                      input logic [31:0] res, input logic [3:0] f, input bit ordy,
                      input bit fl, input bit qc, output bit acc);
    bit pop;
    @(negedge clk);
    check("in_ready", in_ready, mcount < 2);
    check("out_valid", out_valid, mcount != 0);
    check("nzcv", nzcv, {fn, fz, fc, fv});
    check("c_to_alu", c_to_alu, fc);
`ifdef ALU_WB_STICKY_Q_EN
    check("q_flag", q_flag, mq);
`endif
    in_valid = v; in_op = op; in_rd = rd; in_s = s; in_result = res;
    {in_n, in_z, in_c, in_v} = f;
    out_ready = ordy; flush = fl; q_clr = qc;
    pop = (mcount != 0) && ordy;
    acc = v && (mcount < 2);
    if (acc && !model_is_cmp(op) && !fl) exp_q.push_back({rd, res});
    if (fl) mcount = 0;
    else    mcount = mcount + ((acc && !model_is_cmp(op)) ? 1 : 0) - (pop ? 1 : 0);
    if (acc && (model_is_cmp(op) || s)) begin
      fn = f[3]; fz = f[2];
      if (model_is_arith(op)) begin fc = f[1]; fv = f[0]; end
    end
    if (acc && model_is_arith(op) && f[0]) mq = 1'b1;
    else if (qc)                           mq = 1'b0;
  endtask

  task automatic idle(input bit ordy);
    bit a;
    step(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, ordy, 1'b0, 1'b0, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; q_clr = 1'b0;
    exp_q.delete(); mcount = 0; {fn, fz, fc, fv} = 4'b0000; mq = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_rd", out_rd, 4'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_nzcv", nzcv, 4'b0000);
    check("rst_q_flag", q_flag, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every completed write must match the oldest expected entry.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = 'x;
        check("write_rd", out_rd, e[35:32]);
        check("write_data", out_data, e[31:0]);
      end
      if (rst_n && flush) exp_q.delete();
    end
  end

  initial begin
    bit a;
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 4'h0; in_rd = 4'h0; in_s = 1'b0;
    in_result = 32'h0; {in_n, in_z, in_c, in_v} = 4'h0;
    out_ready = 1'b0; flush = 1'b0; q_clr = 1'b0;
    mcount = 0; {fn, fz, fc, fv} = 4'b0000; mq = 1'b0;
    #3;
    check("init_in_ready", in_ready, 1'b1);
    check("init_out_valid", out_valid, 1'b0);
    do_reset();

    // ADC with flag update: write visible next cycle, NZCV=1001.
    step(1'b1, ADC, 4'd3, 1'b1, 32'h8000_0000, 4'b1001, 1'b0, 1'b0, 1'b0, a);
    idle(1'b0);
    check("adc_out_valid", out_valid, 1'b1);
    check("adc_out_rd", out_rd, 4'd3);
    check("adc_out_data", out_data, 32'h8000_0000);
    check("adc_nzcv", nzcv, 4'b1001);
    check("adc_c_to_alu", c_to_alu, 1'b0);

    // CMP updates flags without s and is never queued; LSL keeps C.
    step(1'b1, CMP, 4'd7, 1'b0, 32'h0, 4'b0110, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1);
    check("cmp_nzcv", nzcv, 4'b0110);
    check("cmp_no_write", out_valid, 1'b0);
    step(1'b1, LSL, 4'd4, 1'b1, 32'h0, 4'b0100, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1);
    check("lsl_nzcv_c_held", nzcv, 4'b0110);
    idle(1'b1);

    // Three ORRs with the write port stalled: third waits for space.
    step(1'b1, ORR, 4'd1, 1'b0, 32'h11, 4'h0, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, ORR, 4'd2, 1'b0, 32'h22, 4'h0, 1'b0, 1'b0, 1'b0, a);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ORR, 4'd3, 1'b0, 32'h33, 4'h0, 1'b0, 1'b0, 1'b0, a);
      check("full_stall", a, 1'b0);
    end
    guard = 0;
    do begin
      step(1'b1, ORR, 4'd3, 1'b0, 32'h33, 4'h0, 1'b1, 1'b0, 1'b0, a);
      guard++;
    end while (!a && guard < 8);
    check("third_orr_accepted", a, 1'b1);
    repeat (3) idle(1'b1);

    // Count stays at one under simultaneous push and pop.
    step(1'b1, ORR, 4'd0, 1'b0, 32'h100, 4'h0, 1'b0, 1'b0, 1'b0, a);
    for (int i = 1; i <= 10; i++)
      step(1'b1, ORR, 4'(i), 1'b0, 32'h100 + 32'(i), 4'h0, 1'b1, 1'b0, 1'b0, a);
    check("steady_in_ready", in_ready, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Full buffer flushed while a CMN waits; CMN lands the cycle after.
    step(1'b1, ORR, 4'd5, 1'b0, 32'h55, 4'h0, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, ORR, 4'd6, 1'b0, 32'h66, 4'h0, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, CMN, 4'd0, 1'b0, 32'h0, 4'b1011, 1'b0, 1'b1, 1'b0, a);
    step(1'b1, CMN, 4'd0, 1'b0, 32'h0, 4'b1011, 1'b0, 1'b0, 1'b0, a);
    check("flush_emptied", out_valid, 1'b0);
    idle(1'b1);
    check("cmn_nzcv", nzcv, 4'b1011);

`ifdef ALU_WB_STICKY_Q_EN
    step(1'b1, SBC, 4'd2, 1'b0, 32'h1, 4'b0001, 1'b1, 1'b0, 1'b0, a);
    idle(1'b1);
    check("q_set", q_flag, 1'b1);
    step(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, a);
    idle(1'b1);
    check("q_cleared", q_flag, 1'b0);
    step(1'b1, ADC, 4'd2, 1'b0, 32'h1, 4'b0001, 1'b1, 1'b0, 1'b1, a);
    idle(1'b1);
    check("q_set_wins", q_flag, 1'b1);
`endif

    // Randomised traffic with occasional flushes and mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
           $urandom_range(0, 7) == 0, a);
    end
    repeat (4) idle(1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
